// File: rtl/sub32_pkg.sv
// rtl/sub32_pkg.sv - shared FSM state type and default width for the serial subtractor
package sub32_pkg;

  localparam int SUB32_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub_32.sv
// rtl/serial_sub_32.sv - bit-serial subtractor, one bit per cycle, LSB first
// Optional signed-overflow output ovf enabled by SERIAL_SUB_32_OVERFLOW_EN.
module serial_sub_32
  import sub32_pkg::*;
#(
  parameter int WIDTH = SUB32_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_32_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bo;

  full_subtractor u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = cell_bo;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bo;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
          // brw_q here is the borrow flowing into the MSB
          ovf_d   = brw_q ^ cell_bo;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = in1;
          b_d     = in2;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_32.sv
// tb/tb_serial_sub_32.sv - self-checking bench for serial_sub_32 against an arithmetic model
module tb_serial_sub_32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_32_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_sub_32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_32_OVERFLOW_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  // Model: an accepted start occupies the unit for W cycles, then the
  // arithmetic result appears for one done cycle and is held afterwards.
  bit           m_run = 0;
  bit           m_done = 0;
  int           m_left = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_c = 1'b0;
  logic [W-1:0] e_diff = '0;
  logic         e_bout = 1'b0;
  logic         e_ovf = 1'b0;

  task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      output logic [W-1:0] d, output logic bo, output logic ov);
    logic [W:0] full;
    longint     r;
    full = {1'b0, a} - {1'b0, b} - (W+1)'(c);
    r    = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
    d    = full[W-1:0];
    bo   = full[W];
    ov   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_left = 0;
      e_diff = '0; e_bout = 1'b0; e_ovf = 1'b0;
    end else if (m_run) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_run  = 0;
        m_done = 1;
        calc(m_a, m_b, m_c, e_diff, e_bout, e_ovf);
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_run = 1; m_left = W;
        m_a = in1; m_b = in2; m_c = bin;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", W'(busy), W'(m_run));
    chk("done", W'(done), W'(m_done));
    chk("diff", diff, e_diff);
    chk("bout", W'(bout), W'(e_bout));
`ifdef SERIAL_SUB_32_OVERFLOW_EN
    chk("ovf", W'(ovf), W'(e_ovf));
`endif
  end

  // Called just after a negedge. Returns negedges counted until done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit hold, output int lat);
    in1 = a; in2 = b; bin = c; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      #1;
      if (i == 1 && !hold) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL timeout: done not seen within 40 cycles, required 33");
    end
  endtask

  task automatic chk_result(input string name, input int lat, input logic [W-1:0] d,
                            input logic bo, input logic ov);
    chk({name, "_lat"}, W'(lat), W'(33));
    chk({name, "_diff"}, diff, d);
    chk({name, "_bout"}, W'(bout), W'(bo));
`ifdef SERIAL_SUB_32_OVERFLOW_EN
    chk({name, "_ovf"}, W'(ovf), W'(ov));
`endif
  endtask

  int lat;
  int pulses;

  initial begin
    #2;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_diff", diff, '0);
    chk("rst_bout", W'(bout), '0);
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;

    run_op(32'd5, 32'd3, 1'b0, 0, lat);
    chk_result("v5m3", lat, 32'h0000_0002, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("done_one_cycle", W'(done), '0);
    chk("diff_held", diff, 32'h0000_0002);

    run_op(32'd0, 32'd1, 1'b0, 0, lat);
    chk_result("v0m1", lat, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'd10, 32'd3, 1'b1, 0, lat);
    chk_result("v10m3b", lat, 32'h0000_0006, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 0, lat);
    chk_result("vmin", lat, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat);
    chk_result("vmax", lat, 32'h8000_0000, 1'b1, 1'b1);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0, lat);
    chk_result("veqb", lat, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // start during RUN must be ignored
    in1 = 32'd100; in2 = 32'd58; bin = 1'b0; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #1 in1 = 32'hDEAD_BEEF; in2 = 32'd7; bin = 1'b1; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) begin
        pulses++;
        chk("ign_diff", diff, 32'd42);
        chk("ign_bout", W'(bout), '0);
      end
    end
    chk("ign_pulses", W'(pulses), W'(1));

    // reset in the middle of RUN
    run_op(32'd9, 32'd4, 1'b0, 0, lat);
    chk("pre_rst_diff", diff, 32'd5);
    @(negedge clk); #1;
    in1 = 32'd77; in2 = 32'd1; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_done", W'(done), '0);
    chk("mid_rst_diff", diff, '0);
    chk("mid_rst_bout", W'(bout), '0);
    @(negedge clk); #1 rst = 1'b0;
    run_op(32'd1000, 32'd1, 1'b1, 0, lat);
    chk_result("post_rst", lat, 32'd998, 1'b0, 1'b0);

    // start held in DONE gives back-to-back operations
    @(negedge clk); #1;
    run_op(32'd20, 32'd5, 1'b0, 1, lat);
    chk_result("b2b_first", lat, 32'd15, 1'b0, 1'b0);
    in1 = 32'd3; in2 = 32'd4; bin = 1'b0;
    run_op(32'd3, 32'd4, 1'b0, 1, lat);
    chk_result("b2b_second", lat, 32'hFFFF_FFFF, 1'b1, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("final_idle", W'(busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub_32.md
SERIAL_SUB_32 -- requirements
Module: serial_sub_32

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction.
REQ-005 SHALL have port: in1  input  WIDTH  minuend.
REQ-006 SHALL have port: in2  input  WIDTH  subtrahend.
REQ-007 SHALL have port: bin  input  1  borrow-in.
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port: diff  output  WIDTH  result in1 - in2 - bin, modulo 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  borrow-out; 1 when unsigned in1 < in2 + bin.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL sample start only in IDLE or DONE; when start=1, SHALL latch in1, in2 and bin into internal registers and enter RUN on the same edge.
REQ-014 SHALL ignore start while in RUN; latched operands SHALL be unaffected.
REQ-015 SHALL process one bit per cycle in RUN, LSB first, through a borrow flip-flop seeded with the latched bin.
REQ-016 SHALL hold a bit counter that counts 0..WIDTH-1 in RUN, then transition RUN->DONE after the cycle that processes bit WIDTH-1.
REQ-017 SHALL give latency: start sampled at edge N -> done=1 during cycle N+WIDTH+1 (cycle 33 for WIDTH=32).
REQ-018 SHALL assert busy=1 exactly while in RUN.
REQ-019 SHALL assert done=1 only in DONE, for exactly one cycle; DONE->IDLE unless start=1, in which case DONE->RUN.
REQ-020 SHALL update diff and bout only when entering DONE, and hold them stable until the next completion.
REQ-021 SHALL set bout to the borrow flip-flop value after bit WIDTH-1.

Reset
REQ-022 SHALL, on rst=1 at any time including mid-RUN, force IDLE, busy=0, done=0, diff=0, bout=0 and counter=0, and clear the borrow flip-flop; any partial result SHALL be discarded.
REQ-023 SHALL accept a new start on the first clock edge after rst deasserts.

Configuration
REQ-024 SHALL use macro SERIAL_SUB_32_OVERFLOW_EN.
REQ-025 SHALL, when the macro is defined, add output port ovf (1 bit), reset to 0 and updated with diff; ovf=1 when the signed two's-complement result overflows, i.e. the borrow into the MSB differs from bout.
REQ-026 SHALL, when the macro is undefined, have no ovf port and no associated logic.

Structure
REQ-027 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the default width constant in shared package sub32_pkg.
REQ-028 SHALL instantiate one sub-module, full_subtractor (d = a^b^bi; bo = ~a&b | ~(a^b)&bi), for the per-bit cell.

Verification
REQ-029 SHALL cover: in1=5, in2=3, bin=0, start pulse -> done at cycle 33, diff=0x00000002, bout=0.
REQ-030 SHALL cover: in1=0, in2=1, bin=0 -> diff=0xFFFFFFFF, bout=1; and in1=10, in2=3, bin=1 -> diff=0x00000006, bout=0.
REQ-031 SHALL cover: in1=0x80000000, in2=1, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1 when the macro is defined.
REQ-032 SHALL cover: start at cycle 10 of RUN with different operands -> ignored; first result unchanged; done pulses once.
REQ-033 SHALL cover: rst at cycle 15 of RUN -> busy=0, done=0, diff=0 immediately; a fresh start after reset gives a correct result at +33 cycles.
REQ-034 SHALL cover: start held high in DONE -> back-to-back operations, with done pulses exactly 33 cycles apart.
